// File: rtl/hub75_pkg.sv
// Shared HUB75 types and frame geometry for the image double buffer.
package hub75_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        PENDING = 2'd2
    } frame_swap_st_t;

    localparam int HUB75_FRAME_ADDR_W = 8;
    localparam int HUB75_FRAME_LAST   = 191;

endpackage

// File: rtl/hub75_frame_swap.sv
// Double-buffer bank scheduler for the HUB75 image BRAM: writes go to the back bank, reads to the front.
// Optional dropped-frame counter is enabled by defining HUB75_FRAME_SWAP_STATS_EN.
module hub75_frame_swap
    import hub75_pkg::*;
#(
    parameter int                ADDR_W    = HUB75_FRAME_ADDR_W,
    parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(HUB75_FRAME_LAST)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              frame_sync,
    input  logic              hold,
    output logic [ADDR_W:0]   bram_wr_addr,
    output logic [ADDR_W:0]   bram_rd_addr,
    output logic              front_bank,
    output logic              swap_pending,
    output logic [7:0]        drop_cnt
);

    frame_swap_st_t st_reg;
    logic           front_bank_reg;
    logic           wr_last;
    logic           wr_drop;

    assign wr_last = wr_en && (wr_addr == LAST_ADDR);
    // A non-final write while a finished frame waits means that frame is lost.
    assign wr_drop = wr_en && !wr_last && (st_reg == PENDING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_reg         <= EMPTY;
            front_bank_reg <= 1'b0;
        end else begin
            if (wr_last) begin
                st_reg <= PENDING;
            end else if (wr_en) begin
                st_reg <= FILLING;
            end else if (st_reg == PENDING && frame_sync && !hold) begin
                st_reg         <= EMPTY;
                front_bank_reg <= ~front_bank_reg;
            end
        end
    end

`ifdef HUB75_FRAME_SWAP_STATS_EN
    logic [7:0] drop_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_reg <= 8'h00;
        end else if (wr_drop && drop_cnt_reg != 8'hFF) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`else
    logic unused_drop;
    assign unused_drop = wr_drop;
    assign drop_cnt    = 8'h00;
`endif

    assign front_bank   = front_bank_reg;
    assign swap_pending = (st_reg == PENDING);
    assign bram_wr_addr = {~front_bank_reg, wr_addr};
    assign bram_rd_addr = {front_bank_reg, rd_addr};

endmodule

// File: tb/tb_hub75_frame_swap.sv
// Directed bench for hub75_frame_swap: swap timing, early sync, overwrite, collision, hold and reset.
module tb_hub75_frame_swap;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] rd_addr;
    logic       frame_sync;
    logic       hold;
    logic [8:0] bram_wr_addr;
    logic [8:0] bram_rd_addr;
    logic       front_bank;
    logic       swap_pending;
    logic [7:0] drop_cnt;

    int tests_run = 0;
    int tests_failed = 0;

`ifdef HUB75_FRAME_SWAP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    hub75_frame_swap dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .frame_sync   (frame_sync),
        .hold         (hold),
        .bram_wr_addr (bram_wr_addr),
        .bram_rd_addr (bram_rd_addr),
        .front_bank   (front_bank),
        .swap_pending (swap_pending),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic wr(input int a);
        wr_en   = 1'b1;
        wr_addr = a[7:0];
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wr_range(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) wr(a);
    endtask

    task automatic sync_pulse();
        frame_sync = 1'b1;
        @(posedge clk);
        #1;
        frame_sync = 1'b0;
    endtask

    task automatic wr_sync(input int a);
        wr_en      = 1'b1;
        wr_addr    = a[7:0];
        frame_sync = 1'b1;
        @(posedge clk);
        #1;
        wr_en      = 1'b0;
        frame_sync = 1'b0;
    endtask

    function automatic logic [31:0] exp_drop(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    initial begin
        #10ms;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = 8'd5;
        rd_addr    = 8'd7;
        frame_sync = 1'b0;
        hold       = 1'b0;
        #1;
        check("reset_wr_addr", 32'(bram_wr_addr), 32'h105);
        check("reset_rd_addr", 32'(bram_rd_addr), 32'h007);
        check("reset_front", 32'(front_bank), 0);
        check("reset_pending", 32'(swap_pending), 0);
        check("reset_drop", 32'(drop_cnt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Normal swap
        wr_range(0, 190);
        check("fill_not_pending", 32'(swap_pending), 0);
        wr(191);
        check("complete_pending", 32'(swap_pending), 1);
        check("complete_front0", 32'(front_bank), 0);
        sync_pulse();
        check("swap_front1", 32'(front_bank), 1);
        check("swap_pending_clr", 32'(swap_pending), 0);
        rd_addr = 8'd7;
        wr_addr = 8'd5;
        #1;
        check("swap_rd_addr", 32'(bram_rd_addr), 32'h107);
        check("swap_wr_addr", 32'(bram_wr_addr), 32'h005);

        // Early sync, plus an out-of-frame address that must not complete
        wr_range(0, 100);
        sync_pulse();
        check("early_front", 32'(front_bank), 1);
        check("early_pending", 32'(swap_pending), 0);
        wr(250);
        check("above_last_pending", 32'(swap_pending), 0);
        check("above_last_wr_addr", 32'(bram_wr_addr), 32'h0FA);
        wr_range(101, 191);
        check("early_complete", 32'(swap_pending), 1);
        sync_pulse();
        check("early_swap_front", 32'(front_bank), 0);

        // Collision: write beats sync in PENDING
        wr(191);
        check("coll_pending", 32'(swap_pending), 1);
        wr_sync(0);
        check("coll_front", 32'(front_bank), 0);
        check("coll_pending_clr", 32'(swap_pending), 0);
        check("coll_drop", 32'(drop_cnt), exp_drop(1));
        // Completion and sync together: sync ignored
        wr_sync(191);
        check("cs_front", 32'(front_bank), 0);
        check("cs_pending", 32'(swap_pending), 1);
        sync_pulse();
        check("cs_next_sync", 32'(front_bank), 1);

        // Overwrite and saturation
        wr(191);
        wr(0);
        check("ovw_pending", 32'(swap_pending), 0);
        check("ovw_drop", 32'(drop_cnt), exp_drop(2));
        for (int i = 0; i < 300; i++) begin
            wr(191);
            wr(0);
        end
        check("ovw_saturate", 32'(drop_cnt), exp_drop(255));
        check("ovw_front", 32'(front_bank), 1);

        // Hold
        wr(191);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) sync_pulse();
        check("hold_front", 32'(front_bank), 1);
        check("hold_pending", 32'(swap_pending), 1);
        hold = 1'b0;
        sync_pulse();
        check("unhold_swap", 32'(front_bank), 0);
        wr(191);
        sync_pulse();
        check("preset_front", 32'(front_bank), 1);

        // Asynchronous reset mid-frame
        wr_range(0, 50);
        wr(191);
        check("prerst_pending", 32'(swap_pending), 1);
        #10;
        rst_n = 1'b0;
        #1;
        check("arst_front", 32'(front_bank), 0);
        check("arst_pending", 32'(swap_pending), 0);
        check("arst_drop", 32'(drop_cnt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr(3);
        check("post_rst_pending", 32'(swap_pending), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
